fleet_tracker: RTL



---
 rtl/fleet_pkg.sv | 32 +++
 rtl/cell_map.sv | 69 ++++++
 rtl/fleet_tracker.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fleet_pkg.sv
// Shared definitions for the Battleship fleet bookkeeping and the game FSM.
// Contents:
//   phase_t  - tracker phase encoding (PLACE, ARMED, RESOLVE, OVER)
//   cell_w_f - width of a cell index for a board of 'cells' cells
//   id_w_f   - width of a ship id / ship count for 'ships' ships (id 0 = empty)
//   cnt_w_f  - width of a per-ship remaining-cell counter (0..cells)
package fleet_pkg;

  typedef enum logic [1:0] {
    PLACE   = 2'd0,
    ARMED   = 2'd1,
    RESOLVE = 2'd2,
    OVER    = 2'd3
  } phase_t;

  function automatic int cell_w_f(input int cells);
    if (cells > 1) begin
      return $clog2(cells);
    end else begin
      return 1;
    end
  endfunction

  function automatic int id_w_f(input int ships);
    return $clog2(ships + 1);
  endfunction

  function automatic int cnt_w_f(input int cells);
    return $clog2(cells + 1);
  endfunction

endpackage

// File: rtl/cell_map.sv
// Per-cell board storage: ship owner of every cell and the shot bitmap.
// Ports:
//   clk_i, rst_i (async, active-high), clear_i (synchronous wipe)
//   own_we_i/own_waddr_i/own_wdata_i - owner write port
//   shot_we_i/shot_waddr_i           - marks a cell as shot
//   rd_addr_i -> rd_owner_o, rd_shot_o - combinational read; out-of-range
//                                        indices read as empty / not shot
module cell_map #(
  parameter int CELLS  = 25,
  parameter int CELL_W = 5,
  parameter int ID_W   = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              own_we_i,
  input  logic [CELL_W-1:0] own_waddr_i,
  input  logic [ID_W-1:0]   own_wdata_i,
  input  logic              shot_we_i,
  input  logic [CELL_W-1:0] shot_waddr_i,
  input  logic [CELL_W-1:0] rd_addr_i,
  output logic [ID_W-1:0]   rd_owner_o,
  output logic              rd_shot_o
);

  localparam logic [CELL_W:0] CELLS_L = (CELL_W + 1)'(CELLS);

  logic [ID_W-1:0]  owner_q [CELLS];
  logic [CELLS-1:0] shot_q;
  logic             rd_in_range;

  assign rd_in_range = ({1'b0, rd_addr_i} < CELLS_L);

  // Owner and shot storage; writes decoded per cell so no index can run off the array.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < CELLS; i++) begin
        owner_q[i] <= {ID_W{1'b0}};
      end
      shot_q <= {CELLS{1'b0}};
    end else if (clear_i) begin
      for (int i = 0; i < CELLS; i++) begin
        owner_q[i] <= {ID_W{1'b0}};
      end
      shot_q <= {CELLS{1'b0}};
    end else begin
      for (int i = 0; i < CELLS; i++) begin
        if (own_we_i && (own_waddr_i == CELL_W'(i))) begin
          owner_q[i] <= own_wdata_i;
        end
        if (shot_we_i && (shot_waddr_i == CELL_W'(i))) begin
          shot_q[i] <= 1'b1;
        end
      end
    end
  end

  // Combinational read port.
  always_comb begin
    if (rd_in_range) begin
      rd_owner_o = owner_q[rd_addr_i];
      rd_shot_o  = shot_q[rd_addr_i];
    end else begin
      rd_owner_o = {ID_W{1'b0}};
      rd_shot_o  = 1'b0;
    end
  end

endmodule

// File: rtl/fleet_tracker.sv
// Board and fleet bookkeeping for one Battleship side.
// Ports:
//   clk_i, rst_i (async, active-high), clear_i (synchronous wipe to PLACE)
//   place_en_i/place_cell_i/place_ship_i -> place_ack_o/place_err_o pulses
//   start_i -> enters ARMED, or start_err_o pulse on an empty fleet
//   shot_valid_i/shot_cell_i/shot_ready_o - shot handshake
//   res_valid_o/res_hit_o/res_repeat_o/res_sunk_o/res_ship_o - one-cycle result
//   sunk_mask_o, ships_left_o, all_sunk_o, phase_o - fleet status
module fleet_tracker
  import fleet_pkg::*;
#(
  parameter  int CELLS  = 25,
  parameter  int SHIPS  = 5,
  localparam int CELL_W = cell_w_f(CELLS),
  localparam int ID_W   = id_w_f(SHIPS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              place_en_i,
  input  logic [CELL_W-1:0] place_cell_i,
  input  logic [ID_W-1:0]   place_ship_i,
  output logic              place_ack_o,
  output logic              place_err_o,
  input  logic              start_i,
  output logic              start_err_o,
  input  logic              shot_valid_i,
  input  logic [CELL_W-1:0] shot_cell_i,
  output logic              shot_ready_o,
  output logic              res_valid_o,
  output logic              res_hit_o,
  output logic              res_repeat_o,
  output logic              res_sunk_o,
  output logic [ID_W-1:0]   res_ship_o,
  output logic [SHIPS-1:0]  sunk_mask_o,
  output logic [ID_W-1:0]   ships_left_o,
  output logic              all_sunk_o,
  output logic [1:0]        phase_o
);

  localparam int              CNT_W   = cnt_w_f(CELLS);
  localparam logic [CELL_W:0] CELLS_L = (CELL_W + 1)'(CELLS);
  localparam logic [ID_W-1:0] SHIPS_L = ID_W'(SHIPS);

  phase_t            phase_q, phase_d;
  logic [CELL_W-1:0] shot_cell_q, shot_cell_d;
  logic [CNT_W-1:0]  remain_q [SHIPS];
  logic [CNT_W-1:0]  remain_d [SHIPS];
  logic [SHIPS-1:0]  sunk_mask_q, sunk_mask_d;
  logic [ID_W-1:0]   ships_left_q, ships_left_d;
  logic              place_ack_q, place_ack_d, place_err_q, place_err_d;
  logic              start_err_q, start_err_d;
  logic              res_valid_q, res_valid_d, res_hit_q, res_hit_d;
  logic              res_repeat_q, res_repeat_d, res_sunk_q, res_sunk_d;
  logic [ID_W-1:0]   res_ship_q, res_ship_d;
  logic              shot_ready_q, all_sunk_q;

  logic [CELL_W-1:0] rd_addr;
  logic [ID_W-1:0]   rd_owner;
  logic              rd_shot;
  logic              own_we, shot_we;
  logic [ID_W-1:0]   own_wdata;
  logic              place_bad, shot_repeat, shot_sinks;
  logic [ID_W-1:0]   afloat_cnt;
  logic [CNT_W-1:0]  owner_remain;

  // The read port serves the placement target, except while a shot resolves.
  assign rd_addr = (phase_q == RESOLVE) ? shot_cell_q : place_cell_i;

  cell_map #(
    .CELLS (CELLS),
    .CELL_W(CELL_W),
    .ID_W  (ID_W)
  ) u_cell_map (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (clear_i),
    .own_we_i    (own_we),
    .own_waddr_i (place_cell_i),
    .own_wdata_i (own_wdata),
    .shot_we_i   (shot_we),
    .shot_waddr_i(shot_cell_q),
    .rd_addr_i   (rd_addr),
    .rd_owner_o  (rd_owner),
    .rd_shot_o   (rd_shot)
  );

  assign place_bad = ({1'b0, place_cell_i} >= CELLS_L) || (place_ship_i > SHIPS_L) ||
                     ((place_ship_i != {ID_W{1'b0}}) && (rd_owner != {ID_W{1'b0}}));
  assign shot_repeat = ({1'b0, shot_cell_q} >= CELLS_L) || rd_shot;
  // A hit sinks the ship when it removes that ship's last remaining cell.
  assign shot_sinks  = !shot_repeat && (rd_owner != {ID_W{1'b0}}) &&
                       (owner_remain == CNT_W'(1));

  // Ships with cells left, and the remaining count of the ship at the read cell.
  always_comb begin
    afloat_cnt   = {ID_W{1'b0}};
    owner_remain = {CNT_W{1'b0}};
    for (int i = 0; i < SHIPS; i++) begin
      if (remain_q[i] != {CNT_W{1'b0}}) begin
        afloat_cnt = afloat_cnt + ID_W'(1);
      end else begin
        afloat_cnt = afloat_cnt;
      end
      if (rd_owner == ID_W'(i + 1)) begin
        owner_remain = remain_q[i];
      end else begin
        owner_remain = owner_remain;
      end
    end
  end

  // Phase state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q <= PLACE;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Next-phase logic; clear overrides everything. place_en wins over start.
  always_comb begin
    phase_d = phase_q;
    if (clear_i) begin
      phase_d = PLACE;
    end else begin
      case (phase_q)
        PLACE: begin
          if (!place_en_i && start_i && (afloat_cnt != {ID_W{1'b0}})) begin
            phase_d = ARMED;
          end else begin
            phase_d = PLACE;
          end
        end
        ARMED: begin
          if (shot_valid_i) begin
            phase_d = RESOLVE;
          end else begin
            phase_d = ARMED;
          end
        end
        RESOLVE: begin
          if (shot_sinks && (ships_left_q == ID_W'(1))) begin
            phase_d = OVER;
          end else begin
            phase_d = ARMED;
          end
        end
        OVER:    phase_d = OVER;
        default: phase_d = PLACE;
      endcase
    end
  end

  // Per-phase outputs and datapath updates (board writes, counters, results).
  always_comb begin
    place_ack_d  = 1'b0;
    place_err_d  = 1'b0;
    start_err_d  = 1'b0;
    res_valid_d  = 1'b0;
    res_hit_d    = 1'b0;
    res_repeat_d = 1'b0;
    res_sunk_d   = 1'b0;
    res_ship_d   = {ID_W{1'b0}};
    own_we       = 1'b0;
    own_wdata    = {ID_W{1'b0}};
    shot_we      = 1'b0;
    shot_cell_d  = shot_cell_q;
    sunk_mask_d  = sunk_mask_q;
    ships_left_d = ships_left_q;
    remain_d     = remain_q;
    case (phase_q)
      PLACE: begin
        if (place_en_i) begin
          if (place_bad) begin
            place_err_d = 1'b1;
          end else begin
            place_ack_d = 1'b1;
            if (place_ship_i != {ID_W{1'b0}}) begin
              own_we    = 1'b1;
              own_wdata = place_ship_i;
              for (int i = 0; i < SHIPS; i++) begin
                if (place_ship_i == ID_W'(i + 1)) begin
                  remain_d[i] = remain_q[i] + CNT_W'(1);
                end else begin
                  remain_d[i] = remain_q[i];
                end
              end
            end else if (rd_owner != {ID_W{1'b0}}) begin
              own_we = 1'b1;
              for (int i = 0; i < SHIPS; i++) begin
                if (rd_owner == ID_W'(i + 1)) begin
                  remain_d[i] = remain_q[i] - CNT_W'(1);
                end else begin
                  remain_d[i] = remain_q[i];
                end
              end
            end else begin
              own_we = 1'b0;
            end
          end
        end else if (start_i) begin
          if (afloat_cnt == {ID_W{1'b0}}) begin
            start_err_d = 1'b1;
          end else begin
            ships_left_d = afloat_cnt;
          end
        end else begin
          start_err_d = 1'b0;
        end
      end
      ARMED: begin
        if (shot_valid_i) begin
          shot_cell_d = shot_cell_i;
        end else begin
          shot_cell_d = shot_cell_q;
        end
      end
      RESOLVE: begin
        res_valid_d = 1'b1;
        if (shot_repeat) begin
          res_repeat_d = 1'b1;
        end else begin
          shot_we = 1'b1;
          if (rd_owner != {ID_W{1'b0}}) begin
            res_hit_d  = 1'b1;
            res_ship_d = rd_owner;
            res_sunk_d = shot_sinks;
            for (int i = 0; i < SHIPS; i++) begin
              if (rd_owner == ID_W'(i + 1)) begin
                remain_d[i] = remain_q[i] - CNT_W'(1);
                sunk_mask_d[i] = sunk_mask_q[i] | shot_sinks;
              end else begin
                remain_d[i] = remain_q[i];
              end
            end
            if (shot_sinks) begin
              ships_left_d = ships_left_q - ID_W'(1);
            end else begin
              ships_left_d = ships_left_q;
            end
          end else begin
            res_hit_d = 1'b0;
          end
        end
      end
      OVER:    res_valid_d = 1'b0;
      default: res_valid_d = 1'b0;
    endcase
  end

  // Counters, captured shot cell and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || clear_i) begin
      shot_cell_q  <= {CELL_W{1'b0}};
      sunk_mask_q  <= {SHIPS{1'b0}};
      ships_left_q <= {ID_W{1'b0}};
      place_ack_q  <= 1'b0;
      place_err_q  <= 1'b0;
      start_err_q  <= 1'b0;
      res_valid_q  <= 1'b0;
      res_hit_q    <= 1'b0;
      res_repeat_q <= 1'b0;
      res_sunk_q   <= 1'b0;
      res_ship_q   <= {ID_W{1'b0}};
      shot_ready_q <= 1'b0;
      all_sunk_q   <= 1'b0;
      for (int i = 0; i < SHIPS; i++) begin
        remain_q[i] <= {CNT_W{1'b0}};
      end
    end else begin
      shot_cell_q  <= shot_cell_d;
      sunk_mask_q  <= sunk_mask_d;
      ships_left_q <= ships_left_d;
      place_ack_q  <= place_ack_d;
      place_err_q  <= place_err_d;
      start_err_q  <= start_err_d;
      res_valid_q  <= res_valid_d;
      res_hit_q    <= res_hit_d;
      res_repeat_q <= res_repeat_d;
      res_sunk_q   <= res_sunk_d;
      res_ship_q   <= res_ship_d;
      shot_ready_q <= (phase_d == ARMED);
      all_sunk_q   <= (phase_d == OVER);
      remain_q     <= remain_d;
    end
  end

  assign place_ack_o  = place_ack_q;
  assign place_err_o  = place_err_q;
  assign start_err_o  = start_err_q;
  assign shot_ready_o = shot_ready_q;
  assign res_valid_o  = res_valid_q;
  assign res_hit_o    = res_hit_q;
  assign res_repeat_o = res_repeat_q;
  assign res_sunk_o   = res_sunk_q;
  assign res_ship_o   = res_ship_q;
  assign sunk_mask_o  = sunk_mask_q;
  assign ships_left_o = ships_left_q;
  assign all_sunk_o   = all_sunk_q;
  assign phase_o      = phase_q;

endmodule
